// File: rtl/ce_frac_gen_pkg.sv
// Shared constants and elaboration helpers for the fractional clock-enable generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ce_frac_gen_pkg;

    localparam int unsigned CE_ACC_W_DEF = 16;
    localparam int unsigned CE_MAX_CH    = 16;

    // Rounded increment for a target enable rate: round(f_ce * 2^acc_w / f_clk).
    function automatic logic [31:0] ce_inc(input longint unsigned f_clk_hz,
                                           input longint unsigned f_ce_hz,
                                           input int unsigned     acc_w);
        longint unsigned num;
        num = (f_ce_hz << acc_w) + (f_clk_hz >> 1);
        return 32'(num / f_clk_hz);
    endfunction

endpackage

// File: rtl/ce_frac_ch.sv
// One phase-accumulator channel: increment register, accumulator, registered ce_p/ce_n.
// Latency: carry in cycle t appears on ce_p in cycle t+1; optional ce_n via CE_FRAC_GEN_NEG_EN.
// Backpressure: none; pause holds the accumulator, resync zeroes it.
module ce_frac_ch
    import ce_frac_gen_pkg::*;
#(
    parameter int unsigned       ACC_W   = CE_ACC_W_DEF,
    parameter logic [ACC_W-1:0]  INC_RST = {1'b1, {(ACC_W-1){1'b0}}}
) (
    input  logic             clk_sys,
    input  logic             res_n,
    input  logic             pause,
    input  logic             resync,
    input  logic             inc_we,
    input  logic [ACC_W-1:0] inc_val,
    output logic             ce_p,
    output logic             ce_n
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc};

    // The write lands after this cycle's accumulation, so the old increment is used once more.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            acc  <= '0;
            inc  <= INC_RST;
            ce_p <= 1'b0;
        end else begin
            if (inc_we) begin
                inc <= inc_val;
            end
            if (resync) begin
                acc  <= '0;
                ce_p <= 1'b0;
            end else if (pause) begin
                ce_p <= 1'b0;
            end else begin
                acc  <= sum[ACC_W-1:0];
                ce_p <= sum[ACC_W];
            end
        end
    end

`ifdef CE_FRAC_GEN_NEG_EN
    // Half-point crossing from the lower half into the upper half without a wrap.
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            ce_n <= 1'b0;
        end else if (resync || pause) begin
            ce_n <= 1'b0;
        end else begin
            ce_n <= ~sum[ACC_W] & sum[ACC_W-1] & ~acc[ACC_W-1];
        end
    end
`else
    assign ce_n = 1'b0;
`endif

endmodule

// File: rtl/ce_frac_gen.sv
// Multi-channel fractional clock-enable generator; ce_n built only with CE_FRAC_GEN_NEG_EN.
// Latency: registered outputs, one cycle from carry to ce_p.
// Backpressure: none; pause/resync fan out to all channels, writes to absent channels are dropped.
module ce_frac_gen
    import ce_frac_gen_pkg::*;
#(
    parameter int unsigned       NUM_CH  = 4,
    parameter int unsigned       ACC_W   = CE_ACC_W_DEF,
    parameter logic [ACC_W-1:0]  INC_RST = {1'b1, {(ACC_W-1){1'b0}}}
) (
    input  logic              clk_sys,
    input  logic              res_n,
    input  logic              pause,
    input  logic              resync,
    input  logic              inc_we,
    input  logic [3:0]        inc_ch,
    input  logic [ACC_W-1:0]  inc_val,
    output logic [NUM_CH-1:0] ce_p,
    output logic [NUM_CH-1:0] ce_n
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic ch_we;

        // Indices >= NUM_CH never match, so such writes vanish.
        assign ch_we = inc_we && (inc_ch == 4'(k));

        ce_frac_ch #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_RST)
        ) u_ch (
            .clk_sys (clk_sys),
            .res_n   (res_n),
            .pause   (pause),
            .resync  (resync),
            .inc_we  (ch_we),
            .inc_val (inc_val),
            .ce_p    (ce_p[k]),
            .ce_n    (ce_n[k])
        );
    end

endmodule

// File: tb/tb_ce_frac_gen.sv
// Randomised and directed bench for ce_frac_gen against an unbounded-phase reference model.
module tb_ce_frac_gen;
    import ce_frac_gen_pkg::*;

    localparam int NUM_CH = 4;
    localparam int ACC_W  = 16;
    localparam longint unsigned FULL = 64'd1 << ACC_W;
    localparam longint unsigned HALF = 64'd1 << (ACC_W - 1);

    logic              clk_sys = 1'b0;
    logic              res_n   = 1'b1;
    logic              pause   = 1'b0;
    logic              resync  = 1'b0;
    logic              inc_we  = 1'b0;
    logic [3:0]        inc_ch  = '0;
    logic [ACC_W-1:0]  inc_val = '0;
    logic [NUM_CH-1:0] ce_p;
    logic [NUM_CH-1:0] ce_n;

    int checks = 0;
    int errors = 0;

    ce_frac_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) dut (
        .clk_sys (clk_sys),
        .res_n   (res_n),
        .pause   (pause),
        .resync  (resync),
        .inc_we  (inc_we),
        .inc_ch  (inc_ch),
        .inc_val (inc_val),
        .ce_p    (ce_p),
        .ce_n    (ce_n)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference: each channel's phase is an ever-growing integer; a pulse is a crossing of a
    // multiple of 2^ACC_W (ce_p) or of an odd half-point within the same period (ce_n).
    longint unsigned   phase [NUM_CH];
    longint unsigned   minc  [NUM_CH];
    logic [NUM_CH-1:0] exp_p;
    logic [NUM_CH-1:0] exp_n;

    always @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                phase[k] = 0;
                minc[k]  = HALF;
            end
            exp_p = '0;
            exp_n = '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                longint unsigned nxt;
                if (resync) begin
                    phase[k] = 0;
                    exp_p[k] = 1'b0;
                    exp_n[k] = 1'b0;
                end else if (pause) begin
                    exp_p[k] = 1'b0;
                    exp_n[k] = 1'b0;
                end else begin
                    nxt      = phase[k] + minc[k];
                    exp_p[k] = (nxt / FULL) != (phase[k] / FULL);
                    exp_n[k] = ((nxt / FULL) == (phase[k] / FULL)) &&
                               ((nxt / HALF) != (phase[k] / HALF));
                    phase[k] = nxt;
                end
            end
            if (inc_we && inc_ch < NUM_CH) minc[inc_ch] = longint'(inc_val);
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk_sys) begin
        if (cmp_en) begin
            logic [NUM_CH-1:0] want_n;
`ifdef CE_FRAC_GEN_NEG_EN
            want_n = exp_n;
`else
            want_n = '0;
`endif
            checks++;
            if (ce_p !== exp_p) begin
                errors++;
                $display("FAIL model_ce_p t=%0t dut=%h exp=%h", $time, ce_p, exp_p);
            end
            checks++;
            if (ce_n !== want_n) begin
                errors++;
                $display("FAIL model_ce_n t=%0t dut=%h exp=%h", $time, ce_n, want_n);
            end
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic write_inc(input logic [3:0] ch, input logic [ACC_W-1:0] val);
        inc_we  = 1'b1;
        inc_ch  = ch;
        inc_val = val;
        step();
        inc_we  = 1'b0;
    endtask

    initial begin
        int cnt;
        int last;
        int gap_bad;
        logic [NUM_CH-1:0] want_n;

        check("ce_inc_quarter", longint'(ce_inc(64'd1000, 64'd250, 16)), 16384);

        #1 res_n = 1'b0;
        #2 cmp_en = 1'b1;
        step();
        step();
        check("reset_ce_p", longint'(ce_p), 0);
        check("reset_ce_n", longint'(ce_n), 0);

        // Scenario 1: default half-rate increment toggles every channel.
        res_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step();
            check($sformatf("rst_ce_p_c%0d", n), longint'(ce_p), (n % 2 == 0) ? 15 : 0);
`ifdef CE_FRAC_GEN_NEG_EN
            want_n = (n % 2 == 1) ? 4'hF : 4'h0;
`else
            want_n = 4'h0;
`endif
            check($sformatf("rst_ce_n_c%0d", n), longint'(ce_n), longint'(want_n));
        end

        // Scenario 2: 65536/14 on ch1 yields exactly 4681 pulses per 2^16 cycles.
        write_inc(4'd1, 16'h1249);
        cnt = 0;
        last = -1;
        gap_bad = 0;
        for (int c = 0; c < 65536; c++) begin
            step();
            if (ce_p[1]) begin
                if (last >= 0 && (c - last) != 14 && (c - last) != 15) gap_bad++;
                last = c;
                cnt++;
            end
        end
        check("ch1_pulse_count", cnt, 4681);
        check("ch1_bad_gaps", gap_bad, 0);

        // Scenario 3: pause mid-period on ch2 at quarter rate.
        write_inc(4'd2, 16'h4000);
        for (int c = 0; c < 6; c++) step();
        pause = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (ce_p[2] || ce_n[2]) cnt++;
        end
        check("pause_pulses", cnt, 0);
        pause = 1'b0;
        last = -1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (ce_p[2]) begin
                if (last >= 0) check("pause_resume_gap", c - last, 4);
                last = c;
                cnt++;
            end
        end
        check("pause_resume_pulses", cnt, 3);

        // Scenario 4: resync aligns quarter and eighth rate channels.
        write_inc(4'd0, 16'h4000);
        write_inc(4'd1, 16'h2000);
        resync = 1'b1;
        step();
        resync = 1'b0;
        check("resync_ce_p", longint'(ce_p), 0);
        check("resync_ce_n", longint'(ce_n), 0);
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("resync_ch0_k%0d", k), longint'(ce_p[0]), (k % 4 == 0) ? 1 : 0);
            check($sformatf("resync_ch1_k%0d", k), longint'(ce_p[1]), (k % 8 == 0) ? 1 : 0);
        end

        // Scenario 5: out-of-range write is dropped; zero increment silences ch3.
        write_inc(4'd7, 16'h0000);
        cnt = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (ce_p[0]) cnt++;
        end
        check("oob_write_ch0_rate", cnt, 4);
        write_inc(4'd3, 16'h0000);
        step();
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (ce_p[3]) cnt++;
        end
        check("ch3_zero_inc", cnt, 0);

        // Randomised traffic checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            r      = int'($urandom_range(0, 99));
            pause  = (r < 10);
            resync = (r >= 10 && r < 13);
            inc_we = !resync && ($urandom_range(0, 4) == 0);
            inc_ch = 4'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       inc_val = 16'($urandom_range(0, 255));
                1:       inc_val = 16'h1 << $urandom_range(0, 15);
                default: inc_val = 16'($urandom);
            endcase
            step();
        end
        pause  = 1'b0;
        resync = 1'b0;
        inc_we = 1'b0;

        // Asynchronous reset mid-run clears outputs immediately.
        write_inc(4'd0, 16'h8000);
        #2 res_n = 1'b0;
        #1;
        check("async_reset_ce_p", longint'(ce_p), 0);
        check("async_reset_ce_n", longint'(ce_n), 0);
        step();
        res_n = 1'b1;
        for (int c = 0; c < 4; c++) step();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
